// File: rtl/sys_clint_pkg.sv
// Shared constants for sys_clint: register word indices, mcause codes and FSM encodings.
package sys_clint_pkg;

  localparam logic [2:0] IdxMsip    = 3'd0;
  localparam logic [2:0] IdxCmpLo   = 3'd2;
  localparam logic [2:0] IdxCmpHi   = 3'd3;
  localparam logic [2:0] IdxMtimeLo = 3'd4;
  localparam logic [2:0] IdxMtimeHi = 3'd5;

  localparam logic [31:0] CauseSoft  = 32'h8000_0003;
  localparam logic [31:0] CauseTimer = 32'h8000_0007;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitClr = 2'd2
  } irq_state_e;

  typedef enum logic {
    SrcTimer = 1'b0,
    SrcSoft  = 1'b1
  } irq_src_e;

  function automatic logic [31:0] cause_of(irq_src_e src);
    return (src == SrcSoft) ? CauseSoft : CauseTimer;
  endfunction

endpackage

// File: rtl/sys_clint_timer.sv
// Prescaled 64-bit mtime counter, mtimecmp registers and the timer-pending compare.
module sys_clint_timer #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtime_lo_we,
  input  logic        mtime_hi_we,
  input  logic        cmp_lo_we,
  input  logic        cmp_hi_we,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        tip
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     cmp_q, cmp_d;

  always_comb begin
    tick       = (tick_cnt_q == CntMax);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // A CPU write to either half suppresses that cycle's tick; the other half holds.
  always_comb begin
    mtime_d = mtime_q;
    if (mtime_lo_we) begin
      mtime_d[31:0] = wdata;
    end else if (mtime_hi_we) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (cmp_lo_we) cmp_d[31:0]  = wdata;
    if (cmp_hi_we) cmp_d[63:32] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      mtime_q    <= '0;
      cmp_q      <= '1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;
  assign tip      = (mtime_q >= cmp_q);

endmodule

// File: rtl/sys_clint.sv
// Machine timer / software interrupt source with a register slave and valid/ack request.
// Define CLINT_MSIP_EN to include the MSIP register and the software-interrupt path.
module sys_clint
  import sys_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_vld,
  input  logic        mem_wr,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  input  logic        irq_en,
  output logic        irq_vld,
  output logic [31:0] irq_cause,
  input  logic        irq_ack,
  output logic [63:0] mtime_out
);

  logic [2:0]  idx;
  logic        wr_en;
  logic        unused_addr;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        tip;
  logic        sip;

  assign idx         = mem_addr[4:2];
  assign wr_en       = mem_vld & mem_wr;
  assign unused_addr = ^mem_addr[1:0];

  sys_clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .mtime_lo_we(wr_en && (idx == IdxMtimeLo)),
    .mtime_hi_we(wr_en && (idx == IdxMtimeHi)),
    .cmp_lo_we  (wr_en && (idx == IdxCmpLo)),
    .cmp_hi_we  (wr_en && (idx == IdxCmpHi)),
    .wdata      (mem_wdata),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .tip        (tip)
  );

  assign mtime_out = mtime;

`ifdef CLINT_MSIP_EN
  logic msip_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip_q <= 1'b0;
    end else if (wr_en && (idx == IdxMsip)) begin
      msip_q <= mem_wdata[0];
    end
  end

  assign sip = msip_q;
`else
  assign sip = 1'b0;
`endif

  // Bus slave: read data is captured from pre-tick register state on the strobe cycle.
  logic        mem_ack_q;
  logic [31:0] mem_rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    if (mem_vld && !mem_wr) begin
      case (idx)
        IdxMsip:    rdata_d = {31'b0, sip};
        IdxCmpLo:   rdata_d = mtimecmp[31:0];
        IdxCmpHi:   rdata_d = mtimecmp[63:32];
        IdxMtimeLo: rdata_d = mtime[31:0];
        IdxMtimeHi: rdata_d = mtime[63:32];
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ack_q   <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      mem_ack_q   <= mem_vld;
      mem_rdata_q <= rdata_d;
    end
  end

  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;

  // Interrupt handshake
  irq_state_e  state_q, state_d;
  irq_src_e    src_q, src_d;
  logic [31:0] cause_q, cause_d;
  logic        vld_q, vld_d;
  logic        src_pending;

  assign src_pending = (src_q == SrcSoft) ? sip : tip;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cause_d = cause_q;
    vld_d   = vld_q;
    case (state_q)
      StIdle: begin
        if (irq_en && (sip || tip)) begin
          state_d = StReq;
          src_d   = sip ? SrcSoft : SrcTimer;
          cause_d = cause_of(src_d);
          vld_d   = 1'b1;
        end
      end
      StReq: begin
        if (irq_ack) begin
          state_d = StWaitClr;
          vld_d   = 1'b0;
        end else if (!irq_en) begin
          state_d = StIdle;
          vld_d   = 1'b0;
        end
      end
      StWaitClr: begin
        if (!src_pending) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      src_q   <= SrcTimer;
      cause_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cause_q <= cause_d;
      vld_q   <= vld_d;
    end
  end

  assign irq_vld   = vld_q;
  assign irq_cause = cause_q;

endmodule

// File: tb/tb_sys_clint.sv
// Self-checking bench for sys_clint: register table, timer/soft request sequences, reset.
module tb_sys_clint;
  import sys_clint_pkg::*;

  localparam int unsigned TickDiv = 100;

`ifdef CLINT_MSIP_EN
  localparam logic [31:0] MsipRd     = 32'd1;
  localparam logic [31:0] FirstCause = 32'h8000_0003;
`else
  localparam logic [31:0] MsipRd     = 32'd0;
  localparam logic [31:0] FirstCause = 32'h8000_0007;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_vld = 1'b0;
  logic        mem_wr = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        irq_en = 1'b0;
  logic        irq_vld;
  logic [31:0] irq_cause;
  logic        irq_ack = 1'b0;
  logic [63:0] mtime_out;

  always #5 clk = ~clk;

  sys_clint #(
    .TICK_DIV(TickDiv)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_vld  (mem_vld),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .irq_en   (irq_en),
    .irq_vld  (irq_vld),
    .irq_cause(irq_cause),
    .irq_ack  (irq_ack),
    .mtime_out(mtime_out)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_q[$];

  // Reference mtime: prescaler wrap increments, CPU writes replace one half.
  logic [63:0] ref_mtime;
  int unsigned ref_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_mtime <= '0;
      ref_cnt   <= 0;
    end else begin
      ref_cnt <= (ref_cnt == TickDiv - 1) ? 0 : ref_cnt + 1;
      if (mem_vld && mem_wr && mem_addr[4:2] == 3'd4) ref_mtime[31:0] <= mem_wdata;
      else if (mem_vld && mem_wr && mem_addr[4:2] == 3'd5) ref_mtime[63:32] <= mem_wdata;
      else if (ref_cnt == TickDiv - 1) ref_mtime <= ref_mtime + 64'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: got no event, want event within bound", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp);
    mem_vld   = 1'b1;
    mem_wr    = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    exp_q.push_back(exp);
    step();
    mem_vld = 1'b0;
    mem_wr  = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic wait_tick_edge();
    for (int i = 0; i < 2 * TickDiv && ref_cnt != TickDiv - 1; i++) step();
    if (ref_cnt != TickDiv - 1) bound_fail("wait_tick");
  endtask

  // Scoreboard: every access owes one ack carrying the queued read data (0 for writes).
  always @(negedge clk) begin
    if (mem_ack) begin
      if (exp_q.size() == 0) bound_fail("unexpected_ack");
      else check("bus_rdata", {32'b0, mem_rdata}, {32'b0, exp_q.pop_front()});
    end
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[15];
  int   highs;

  initial begin
    vecs[0]  = '{1'b1, 5'h08, 32'h89AB_CDEF, 32'h0};
    vecs[1]  = '{1'b1, 5'h0C, 32'h0123_4567, 32'h0};
    vecs[2]  = '{1'b0, 5'h08, 32'h0,         32'h89AB_CDEF};
    vecs[3]  = '{1'b0, 5'h0C, 32'h0,         32'h0123_4567};
    vecs[4]  = '{1'b0, 5'h0B, 32'h0,         32'h89AB_CDEF};
    vecs[5]  = '{1'b0, 5'h04, 32'h0,         32'h0};
    vecs[6]  = '{1'b1, 5'h1C, 32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b0, 5'h1C, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 5'h18, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{1'b0, 5'h00, 32'h0,         MsipRd};
    vecs[11] = '{1'b1, 5'h00, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 5'h00, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 5'h14, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 5'h10, 32'h0,         32'h2};

    repeat (3) step();
    check("rst_irq_vld", irq_vld, 0);
    check("rst_irq_cause", irq_cause, 0);
    check("rst_mem_ack", mem_ack, 0);
    check("rst_mtime_out", mtime_out, 0);
    rst = 1'b1;

    // mtime after 250 cycles at TICK_DIV=100
    repeat (250) step();
    bus(1'b0, 5'h10, 32'h0, 32'd2);
    check("no_irq_idle", irq_vld, 0);

    for (int i = 0; i < 15; i++) bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);

    // Timer request: cmp = 3, request two cycles after the tick reaching 3
    irq_en = 1'b1;
    bus(1'b1, 5'h0C, 32'h0, 32'h0);
    bus(1'b1, 5'h08, 32'd3, 32'h0);
    for (int i = 0; i < 3 * TickDiv && ref_mtime != 64'd3; i++) step();
    if (ref_mtime != 64'd3) bound_fail("wait_mtime3");
    check("mtime_out_3", mtime_out, ref_mtime);
    check("tmr_vld_lat1", irq_vld, 0);
    step();
    check("tmr_vld_lat2", irq_vld, 1);
    check("tmr_cause", irq_cause, 32'h8000_0007);
    pulse_ack();
    check("ack_drop", irq_vld, 0);
    highs = 0;
    repeat (20) begin step(); if (irq_vld) highs++; end
    check("wait_clr_hold", highs, 0);
    bus(1'b1, 5'h08, 32'd100, 32'h0);
    highs = 0;
    repeat (10) begin step(); if (irq_vld) highs++; end
    check("cleared_idle", highs, 0);

    // irq_en gating
    irq_en = 1'b0;
    bus(1'b1, 5'h08, 32'd0, 32'h0);
    highs = 0;
    repeat (10) begin step(); if (irq_vld) highs++; end
    check("en_low_gate", highs, 0);
    irq_en = 1'b1;
    step();
    check("en_rise_vld", irq_vld, 1);
    check("en_rise_cause", irq_cause, 32'h8000_0007);
    irq_en = 1'b0;
    step();
    check("en_fall_vld", irq_vld, 0);

    // Soft vs timer priority
    bus(1'b1, 5'h00, 32'd1, 32'h0);
    irq_en = 1'b1;
    step();
    check("prio_vld", irq_vld, 1);
    check("prio_cause", irq_cause, FirstCause);
    pulse_ack();
    check("prio_ack_drop", irq_vld, 0);
`ifdef CLINT_MSIP_EN
    bus(1'b1, 5'h00, 32'd0, 32'h0);
    for (int i = 0; i < 6 && !irq_vld; i++) step();
    if (!irq_vld) bound_fail("timer_after_soft");
    else check("timer_after_soft_cause", irq_cause, 32'h8000_0007);
    pulse_ack();
`endif
    bus(1'b1, 5'h08, 32'd100, 32'h0);
    highs = 0;
    repeat (5) begin step(); if (irq_vld) highs++; end
    check("final_clear", highs, 0);

    // MTIME_LO write on a tick cycle: write wins, no carry into HI
    irq_en = 1'b0;
    wait_tick_edge();
    bus(1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0);
    bus(1'b0, 5'h10, 32'h0, 32'hFFFF_FFFF);
    bus(1'b0, 5'h14, 32'h0, 32'h0);
    wait_tick_edge();
    step();
    bus(1'b0, 5'h10, 32'h0, 32'h0);
    check("mtime_out_wrap", mtime_out, ref_mtime);

    // Reset mid-handshake
    irq_en = 1'b1;
    for (int i = 0; i < 4 && !irq_vld; i++) step();
    check("pre_rst_vld", irq_vld, 1);
    mem_vld  = 1'b1;
    mem_wr   = 1'b0;
    mem_addr = 5'h10;
    step();
    mem_vld = 1'b0;
    check("pre_rst_ack", mem_ack, 1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_vld", irq_vld, 0);
    check("rst_mid_cause", irq_cause, 0);
    check("rst_mid_ack", mem_ack, 0);
    check("rst_mid_rdata", mem_rdata, 0);
    check("rst_mid_mtime", mtime_out, 0);
    step();
    step();
    rst = 1'b1;
    highs = 0;
    repeat (150) begin step(); if (irq_vld) highs++; end
    check("post_rst_no_irq", highs, 0);
    check("post_rst_mtime", mtime_out, 64'd1);

    repeat (2) step();
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
